// File: rtl/config_write_sequencer_if.sv
// Requester and configuration-register write bus bundle for config_write_sequencer.
// The master modport is the requester side; the slave modport is the sequencer.
interface config_write_sequencer_if;
    logic        req_a;
    logic [1:0]  addr_a;
    logic [15:0] data_a;
    logic        ack_a;
    logic        err_a;
    logic        req_b;
    logic [1:0]  addr_b;
    logic [15:0] data_b;
    logic        ack_b;
    logic        err_b;
    logic        wren;
    logic [1:0]  abus;
    logic [15:0] dbus;
    logic        locked;
    logic        busy;

    modport master (
        output req_a, addr_a, data_a, req_b, addr_b, data_b,
        input  ack_a, err_a, ack_b, err_b, wren, abus, dbus, locked, busy
    );

    modport slave (
        input  req_a, addr_a, data_a, req_b, addr_b, data_b,
        output ack_a, err_a, ack_b, err_b, wren, abus, dbus, locked, busy
    );
endinterface

// File: rtl/config_write_sequencer.sv
// Sole writer of the watchdog configuration register: boot defaults, then
// round-robin single-word writes from two requesters with an INIT safety lock.
//   state    | meaning
//   ST_BOOT  | emitting the four default writes, then settling the lock
//   ST_IDLE  | waiting for an eligible requester (decision edge)
//   ST_ISSUE | one-cycle write or rejection currently on the outputs
module config_write_sequencer #(
    parameter logic [15:0] FWLEN_DEF   = 16'd100,
    parameter logic [15:0] SWLEN_DEF   = 16'd50,
    parameter logic [15:0] RST_LMT_DEF = 16'd3,
    parameter logic [15:0] SERVICE_DEF = 16'h0000
) (
    input logic                     i_clk,
    input logic                     i_rst,
    config_write_sequencer_if.slave if_cfg
);
    typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_ISSUE} state_t;

    state_t      r_state;
    logic [2:0]  r_boot_idx;
    logic        r_ptr_b;
    logic        r_armed_a;
    logic        r_armed_b;
    logic        r_lock_pend;
    logic        r_wren;
    logic [1:0]  r_abus;
    logic [15:0] r_dbus;
    logic        r_ack_a;
    logic        r_err_a;
    logic        r_ack_b;
    logic        r_err_b;
    logic        r_locked;
    logic        r_busy;

    logic        w_elig_a;
    logic        w_elig_b;
    logic        w_grant_b;
    logic [1:0]  w_sel_addr;
    logic [15:0] w_sel_data;
    logic [15:0] w_wdata;
    logic        w_allow;
    logic [1:0]  w_boot_addr;
    logic [15:0] w_boot_data;

    always_comb begin
        w_boot_addr = 2'b10;
        w_boot_data = SERVICE_DEF;
        case (r_boot_idx[1:0])
            2'd0: begin w_boot_addr = 2'b00; w_boot_data = FWLEN_DEF;   end
            2'd1: begin w_boot_addr = 2'b01; w_boot_data = SWLEN_DEF;   end
            2'd2: begin w_boot_addr = 2'b11; w_boot_data = RST_LMT_DEF; end
            default: begin w_boot_addr = 2'b10; w_boot_data = SERVICE_DEF; end
        endcase
    end

    assign w_elig_a   = if_cfg.req_a && r_armed_a;
    assign w_elig_b   = if_cfg.req_b && r_armed_b;
    assign w_grant_b  = w_elig_b && (!w_elig_a || r_ptr_b);
    assign w_sel_addr = w_grant_b ? if_cfg.addr_b : if_cfg.addr_a;
    assign w_sel_data = w_grant_b ? if_cfg.data_b : if_cfg.data_a;
    // Once locked, only the service word may be written and INIT stays set.
    assign w_allow    = !r_locked || (w_sel_addr == 2'b10);
    assign w_wdata    = r_locked ? (w_sel_data | 16'h0008) : w_sel_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_BOOT;
            r_boot_idx  <= 3'd0;
            r_ptr_b     <= 1'b0;
            r_armed_a   <= 1'b1;
            r_armed_b   <= 1'b1;
            r_lock_pend <= 1'b0;
            r_wren      <= 1'b0;
            r_abus      <= 2'b00;
            r_dbus      <= 16'h0000;
            r_ack_a     <= 1'b0;
            r_err_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_err_b     <= 1'b0;
            r_locked    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_ack_a || r_err_a) r_armed_a <= 1'b0;
            if (!if_cfg.req_a)      r_armed_a <= 1'b1;
            if (r_ack_b || r_err_b) r_armed_b <= 1'b0;
            if (!if_cfg.req_b)      r_armed_b <= 1'b1;

            case (r_state)
                ST_BOOT: begin
                    if (r_boot_idx == 3'd4) begin
                        r_wren   <= 1'b0;
                        r_busy   <= 1'b0;
                        r_locked <= SERVICE_DEF[3];
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wren     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_abus     <= w_boot_addr;
                        r_dbus     <= w_boot_data;
                        r_boot_idx <= r_boot_idx + 3'd1;
                    end
                end
                ST_IDLE: begin
                    if (w_elig_a || w_elig_b) begin
                        r_state <= ST_ISSUE;
                        r_busy  <= 1'b1;
                        r_ptr_b <= !w_grant_b;
                        if (w_allow) begin
                            r_wren      <= 1'b1;
                            r_abus      <= w_sel_addr;
                            r_dbus      <= w_wdata;
                            r_ack_a     <= !w_grant_b;
                            r_ack_b     <= w_grant_b;
                            r_lock_pend <= (w_sel_addr == 2'b10) && w_wdata[3];
                        end else begin
                            r_err_a     <= !w_grant_b;
                            r_err_b     <= w_grant_b;
                            r_lock_pend <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wren      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ack_a     <= 1'b0;
                    r_err_a     <= 1'b0;
                    r_ack_b     <= 1'b0;
                    r_err_b     <= 1'b0;
                    r_locked    <= r_locked || r_lock_pend;
                    r_lock_pend <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign if_cfg.wren   = r_wren;
    assign if_cfg.abus   = r_abus;
    assign if_cfg.dbus   = r_dbus;
    assign if_cfg.ack_a  = r_ack_a;
    assign if_cfg.err_a  = r_err_a;
    assign if_cfg.ack_b  = r_ack_b;
    assign if_cfg.err_b  = r_err_b;
    assign if_cfg.locked = r_locked;
    assign if_cfg.busy   = r_busy;
endmodule

// File: tb/tb_config_write_sequencer.sv
// Directed bench for config_write_sequencer: default build plus a build that
// boots already locked.
module tb_config_write_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    config_write_sequencer_if bus0 ();
    config_write_sequencer_if bus1 ();

    config_write_sequencer u_dut0 (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_cfg (bus0)
    );

    config_write_sequencer #(.SERVICE_DEF(16'h0008)) u_dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_cfg (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input string tag, input logic wren, input logic [1:0] abus,
                       input logic [15:0] dbus, input logic busy);
        chk1 ({tag, "/wren"}, bus0.wren, wren);
        chk16({tag, "/abus"}, {14'd0, bus0.abus}, {14'd0, abus});
        chk16({tag, "/dbus"}, bus0.dbus, dbus);
        chk1 ({tag, "/busy"}, bus0.busy, busy);
    endtask

    task automatic hs0(input string tag, input logic ack_a, input logic err_a,
                       input logic ack_b, input logic err_b, input logic locked);
        chk1({tag, "/ack_a"},  bus0.ack_a,  ack_a);
        chk1({tag, "/err_a"},  bus0.err_a,  err_a);
        chk1({tag, "/ack_b"},  bus0.ack_b,  ack_b);
        chk1({tag, "/err_b"},  bus0.err_b,  err_b);
        chk1({tag, "/locked"}, bus0.locked, locked);
    endtask

    task automatic boot0(input string tag);
        tick(); wr0({tag, "_b0"}, 1'b1, 2'b00, 16'd100, 1'b1); hs0({tag, "_b0"}, 0, 0, 0, 0, 0);
        tick(); wr0({tag, "_b1"}, 1'b1, 2'b01, 16'd50, 1'b1);  hs0({tag, "_b1"}, 0, 0, 0, 0, 0);
        tick(); wr0({tag, "_b2"}, 1'b1, 2'b11, 16'd3, 1'b1);   hs0({tag, "_b2"}, 0, 0, 0, 0, 0);
        tick(); wr0({tag, "_b3"}, 1'b1, 2'b10, 16'd0, 1'b1);   hs0({tag, "_b3"}, 0, 0, 0, 0, 0);
        tick(); wr0({tag, "_bd"}, 1'b0, 2'b10, 16'd0, 1'b0);   hs0({tag, "_bd"}, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic exp_b;
        bus0.req_a = 0; bus0.addr_a = 0; bus0.data_a = 0;
        bus0.req_b = 0; bus0.addr_b = 0; bus0.data_b = 0;
        bus1.req_a = 0; bus1.addr_a = 0; bus1.data_a = 0;
        bus1.req_b = 0; bus1.addr_b = 0; bus1.data_b = 0;

        tick(); tick();
        wr0("reset", 1'b0, 2'b00, 16'h0000, 1'b0);
        hs0("reset", 0, 0, 0, 0, 0);
        chk1("reset_lock1", bus1.locked, 1'b0);

        // First boot of both builds; the preset build locks only at boot end.
        rst = 0;
        tick(); wr0("boot0", 1'b1, 2'b00, 16'd100, 1'b1);
        tick(); wr0("boot1", 1'b1, 2'b01, 16'd50, 1'b1);
        tick(); wr0("boot2", 1'b1, 2'b11, 16'd3, 1'b1);
        tick(); wr0("boot3", 1'b1, 2'b10, 16'd0, 1'b1);
        chk16("boot3_dbus1", bus1.dbus, 16'h0008);
        chk1("boot3_lock1", bus1.locked, 1'b0);
        tick(); wr0("boot_done", 1'b0, 2'b10, 16'd0, 1'b0);
        hs0("boot_done", 0, 0, 0, 0, 0);
        chk1("boot_done_lock1", bus1.locked, 1'b1);

        bus1.req_a = 1; bus1.addr_a = 2'b11; bus1.data_a = 16'h0005;
        tick();
        chk1("pre_rej_err", bus1.err_a, 1'b1);
        chk1("pre_rej_ack", bus1.ack_a, 1'b0);
        chk1("pre_rej_wren", bus1.wren, 1'b0);
        chk16("pre_rej_dbus", bus1.dbus, 16'h0008);
        tick();
        chk1("pre_rej_end", bus1.err_a, 1'b0);
        bus1.req_a = 0;
        tick();
        bus1.req_a = 1; bus1.addr_a = 2'b10; bus1.data_a = 16'h0000;
        tick();
        chk1("pre_svc_wren", bus1.wren, 1'b1);
        chk1("pre_svc_ack", bus1.ack_a, 1'b1);
        chk16("pre_svc_dbus", bus1.dbus, 16'h0008);
        tick();
        bus1.req_a = 0;

        // Single write from A, held request must not repeat
        bus0.req_a = 1; bus0.addr_a = 2'b00; bus0.data_a = 16'h01F4;
        tick(); wr0("a_wr", 1'b1, 2'b00, 16'h01F4, 1'b1); hs0("a_wr", 1, 0, 0, 0, 0);
        tick(); wr0("a_end", 1'b0, 2'b00, 16'h01F4, 1'b0); hs0("a_end", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("a_hold_wren", bus0.wren, 1'b0);
            chk1("a_hold_ack", bus0.ack_a, 1'b0);
        end
        bus0.req_a = 0;
        tick(); wr0("a_drop", 1'b0, 2'b00, 16'h01F4, 1'b0);
        bus0.req_a = 1; bus0.addr_a = 2'b01; bus0.data_a = 16'h0123;
        tick(); wr0("a_re", 1'b1, 2'b01, 16'h0123, 1'b1); hs0("a_re", 1, 0, 0, 0, 0);
        tick();
        bus0.req_a = 0;
        tick();

        // Contention after A's single grant: pointer names B first
        for (int i = 0; i < 4; i++) begin
            bus0.req_a = 1; bus0.addr_a = 2'b00; bus0.data_a = 16'hA000 + 16'(i);
            bus0.req_b = 1; bus0.addr_b = 2'b01; bus0.data_b = 16'hB000 + 16'(i);
            exp_b = (i % 2 == 0);
            tick();
            wr0("rr", 1'b1, exp_b ? 2'b01 : 2'b00,
                exp_b ? 16'hB000 + 16'(i) : 16'hA000 + 16'(i), 1'b1);
            hs0("rr", !exp_b, 0, exp_b, 0, 0);
            tick();
            bus0.req_a = 0; bus0.req_b = 0;
            tick();
        end

        // Lock via B, then rejection and forced INIT for A
        bus0.req_b = 1; bus0.addr_b = 2'b10; bus0.data_b = 16'h0008;
        tick(); wr0("lock_wr", 1'b1, 2'b10, 16'h0008, 1'b1); hs0("lock_wr", 0, 0, 1, 0, 0);
        tick(); wr0("lock_end", 1'b0, 2'b10, 16'h0008, 1'b0); hs0("lock_end", 0, 0, 0, 0, 1);
        bus0.req_b = 0;
        bus0.req_a = 1; bus0.addr_a = 2'b00; bus0.data_a = 16'h0010;
        tick(); wr0("lock_rej", 1'b0, 2'b10, 16'h0008, 1'b1); hs0("lock_rej", 0, 1, 0, 0, 1);
        tick(); hs0("lock_rej_end", 0, 0, 0, 0, 1);
        bus0.req_a = 0;
        tick();
        bus0.req_a = 1; bus0.addr_a = 2'b10; bus0.data_a = 16'h0004;
        tick(); wr0("lock_svc", 1'b1, 2'b10, 16'h000C, 1'b1); hs0("lock_svc", 1, 0, 0, 0, 1);
        tick(); hs0("lock_svc_end", 0, 0, 0, 0, 1);
        bus0.req_a = 0;
        tick();

        // Reset mid-boot with both requests pending
        rst = 1;
        bus0.req_a = 1; bus0.addr_a = 2'b11; bus0.data_a = 16'h0777;
        bus0.req_b = 1; bus0.addr_b = 2'b01; bus0.data_b = 16'h0BBB;
        tick(); wr0("rst1", 1'b0, 2'b00, 16'h0000, 1'b0); hs0("rst1", 0, 0, 0, 0, 0);
        rst = 0;
        tick(); wr0("pb0", 1'b1, 2'b00, 16'd100, 1'b1);
        tick(); wr0("pb1", 1'b1, 2'b01, 16'd50, 1'b1);
        rst = 1;
        tick(); wr0("rst_boot", 1'b0, 2'b00, 16'h0000, 1'b0); hs0("rst_boot", 0, 0, 0, 0, 0);
        rst = 0;
        boot0("rb");

        tick(); wr0("post_a", 1'b1, 2'b11, 16'h0777, 1'b1); hs0("post_a", 1, 0, 0, 0, 0);
        tick(); wr0("post_a_end", 1'b0, 2'b11, 16'h0777, 1'b0);
        tick(); wr0("post_b", 1'b1, 2'b01, 16'h0BBB, 1'b1); hs0("post_b", 0, 0, 1, 0, 0);

        // Reset during ISSUE drops the write silently
        rst = 1;
        tick(); wr0("rst_issue", 1'b0, 2'b00, 16'h0000, 1'b0); hs0("rst_issue", 0, 0, 0, 0, 0);
        tick(); hs0("rst_issue2", 0, 0, 0, 0, 0);
        rst = 0;
        bus0.req_a = 0; bus0.req_b = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
